// File: rtl/fetch_if.sv
// Fetch-stage interface: decode-side handshake, execute redirect and instruction memory port.
interface fetch_if #(
  parameter int PC_WIDTH = 32
);
  logic                stall;
  logic                redirect;
  logic [PC_WIDTH-1:0] redirect_pc;
  logic                imem_en;
  logic [PC_WIDTH-1:0] imem_addr;
  logic [31:0]         imem_rdata;
  logic [31:0]         inst_out;
  logic [PC_WIDTH-1:0] pc_out;
  logic                valid_out;

  modport master (
    input  stall, redirect, redirect_pc, imem_rdata,
    output imem_en, imem_addr, inst_out, pc_out, valid_out
  );

  modport slave (
    output stall, redirect, redirect_pc, imem_rdata,
    input  imem_en, imem_addr, inst_out, pc_out, valid_out
  );
endinterface

// File: rtl/fetch_stage.sv
// RISC-V instruction fetch: owns the PC, reads a 1-cycle-latency imem, buffers one
// instruction across decode stalls and squashes wrong-path work on redirects.
module fetch_stage #(
  parameter int                  PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] PC_RESET = PC_WIDTH'(32'h4000_0000),
  parameter logic [31:0]         NOP_INST = 32'h0000_0013
) (
  input  logic   clk,
  input  logic   rst,
  fetch_if.master bus
);

  logic [PC_WIDTH-1:0] pc_p0;
  logic [PC_WIDTH-1:0] resp_pc_p1;
  logic                vld_p1;
  logic                hold_vld_p1;
  logic [31:0]         hold_inst_p1;
  logic                capture;

  function automatic logic [PC_WIDTH-1:0] next_pc(input logic [PC_WIDTH-1:0] pc);
    return pc + PC_WIDTH'(4);
  endfunction

  function automatic logic [PC_WIDTH-1:0] align_pc(input logic [PC_WIDTH-1:0] pc);
    return pc & ~PC_WIDTH'(3);
  endfunction

  // Stage p0: PC and memory request; the PC only moves when decode takes an instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_p0       <= PC_RESET;
      resp_pc_p1  <= PC_RESET;
      vld_p1      <= 1'b0;
      hold_vld_p1 <= 1'b0;
    end else if (bus.redirect) begin
      pc_p0       <= align_pc(bus.redirect_pc);
      vld_p1      <= 1'b0;
      hold_vld_p1 <= 1'b0;
    end else if (bus.stall) begin
      if (capture) hold_vld_p1 <= 1'b1;
    end else begin
      pc_p0       <= next_pc(pc_p0);
      resp_pc_p1  <= pc_p0;
      vld_p1      <= 1'b1;
      hold_vld_p1 <= 1'b0;
    end
  end

  // Stage p1: the hold buffer snapshots the response on the first stalled cycle, because
  // imem_rdata is not guaranteed stable once the read enable drops.
  assign capture = !rst && !bus.redirect && bus.stall && !hold_vld_p1 && vld_p1;

  always_ff @(posedge clk) begin
    if (capture) hold_inst_p1 <= bus.imem_rdata;
  end

  always_comb begin
    bus.imem_addr = pc_p0;
    bus.imem_en   = !rst && (bus.redirect || !bus.stall);
    bus.pc_out    = resp_pc_p1;
    bus.inst_out  = NOP_INST;
    bus.valid_out = 1'b0;
    if (!rst && !bus.redirect) begin
      if (hold_vld_p1) begin
        bus.inst_out  = hold_inst_p1;
        bus.valid_out = 1'b1;
      end else if (vld_p1) begin
        bus.inst_out  = bus.imem_rdata;
        bus.valid_out = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: synchronous imem model plus a queue of expected (pc, inst) pairs.
module tb_fetch_stage;

  localparam logic [31:0] PC_RESET = 32'h4000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  logic corrupt;
  int   total = 0;
  int   bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] e;

  fetch_if #(.PC_WIDTH(32)) bus();

  fetch_stage #(.PC_WIDTH(32), .PC_RESET(PC_RESET), .NOP_INST(NOP_INST)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // Synchronous-read memory; when idle and corrupt is set it returns garbage.
  always @(posedge clk) begin
    if (bus.imem_en) bus.imem_rdata <= memf(bus.imem_addr);
    else if (corrupt) bus.imem_rdata <= 32'hDEAD_BEEF;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0; corrupt = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    total++;
    if (bus.valid_out !== 1'b0 || bus.imem_en !== 1'b0 || bus.inst_out !== NOP_INST || bus.pc_out !== PC_RESET) begin
      bad++;
      $display("FAIL reset_state vld=%b en=%b inst=%h pc=%h want vld=0 en=0 inst=%h pc=%h",
               bus.valid_out, bus.imem_en, bus.inst_out, bus.pc_out, NOP_INST, PC_RESET);
    end
    tick(); rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus.imem_en !== 1'b1 || bus.imem_addr !== PC_RESET || bus.valid_out !== 1'b0) begin
      bad++;
      $display("FAIL reset_first_fetch en=%b addr=%h vld=%b want en=1 addr=%h vld=0",
               bus.imem_en, bus.imem_addr, bus.valid_out, PC_RESET);
    end
    exp_q.push_back(PC_RESET); exp_q.push_back(PC_RESET + 32'd4);
    for (int i = 0; i < 2; i++) begin
      tick(); @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (bus.valid_out !== 1'b1 || bus.pc_out !== e || bus.inst_out !== memf(e)) begin
        bad++;
        $display("FAIL reset_seq vld=%b pc=%h inst=%h want vld=1 pc=%h inst=%h",
                 bus.valid_out, bus.pc_out, bus.inst_out, e, memf(e));
      end
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      tick(); bus.stall = 1'b1; corrupt = 1'b1;
      @(negedge clk);
      total++;
      if (bus.valid_out !== 1'b1 || bus.imem_en !== 1'b0 || bus.pc_out !== 32'h4000_0008 ||
          bus.inst_out !== memf(32'h4000_0008)) begin
        bad++;
        $display("FAIL stall_hold cyc=%0d vld=%b en=%b pc=%h inst=%h want vld=1 en=0 pc=40000008 inst=%h",
                 i, bus.valid_out, bus.imem_en, bus.pc_out, bus.inst_out, memf(32'h4000_0008));
      end
    end
    exp_q.push_back(32'h4000_0008); exp_q.push_back(32'h4000_000C);
    tick(); bus.stall = 1'b0; corrupt = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (i > 0) tick();
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (bus.valid_out !== 1'b1 || bus.pc_out !== e || bus.inst_out !== memf(e)) begin
        bad++;
        $display("FAIL stall_release vld=%b pc=%h inst=%h want vld=1 pc=%h inst=%h",
                 bus.valid_out, bus.pc_out, bus.inst_out, e, memf(e));
      end
    end
  endtask

  task automatic test_redirect();
    tick(); bus.redirect = 1'b1; bus.redirect_pc = 32'h4000_0100;
    @(negedge clk);
    total++;
    if (bus.valid_out !== 1'b0 || bus.inst_out !== NOP_INST || bus.pc_out !== 32'h4000_0010) begin
      bad++;
      $display("FAIL redirect_squash vld=%b inst=%h pc=%h want vld=0 inst=%h pc=40000010",
               bus.valid_out, bus.inst_out, bus.pc_out, NOP_INST);
    end
    tick(); bus.redirect = 1'b0;
    exp_q.push_back(32'h4000_0100);
    @(negedge clk);
    total++;
    if (bus.valid_out !== 1'b0 || bus.imem_addr !== 32'h4000_0100 || bus.imem_en !== 1'b1) begin
      bad++;
      $display("FAIL redirect_fetch vld=%b addr=%h en=%b want vld=0 addr=40000100 en=1",
               bus.valid_out, bus.imem_addr, bus.imem_en);
    end
    tick(); @(negedge clk);
    e = exp_q.pop_front();
    total++;
    if (bus.valid_out !== 1'b1 || bus.pc_out !== e || bus.inst_out !== memf(e)) begin
      bad++;
      $display("FAIL redirect_target vld=%b pc=%h inst=%h want vld=1 pc=%h inst=%h",
               bus.valid_out, bus.pc_out, bus.inst_out, e, memf(e));
    end
  endtask

  task automatic test_redirect_stall();
    tick(); bus.stall = 1'b1;
    @(negedge clk);
    total++;
    if (bus.valid_out !== 1'b1 || bus.pc_out !== 32'h4000_0104) begin
      bad++;
      $display("FAIL rs_prestall vld=%b pc=%h want vld=1 pc=40000104", bus.valid_out, bus.pc_out);
    end
    tick(); bus.redirect = 1'b1; bus.redirect_pc = 32'h4000_0203;
    @(negedge clk);
    total++;
    if (bus.valid_out !== 1'b0 || bus.imem_en !== 1'b1) begin
      bad++;
      $display("FAIL rs_squash vld=%b en=%b want vld=0 en=1", bus.valid_out, bus.imem_en);
    end
    tick(); bus.redirect = 1'b0; bus.stall = 1'b0;
    exp_q.push_back(32'h4000_0200); exp_q.push_back(32'h4000_0204);
    @(negedge clk);
    total++;
    if (bus.valid_out !== 1'b0 || bus.imem_addr !== 32'h4000_0200 || bus.inst_out !== NOP_INST) begin
      bad++;
      $display("FAIL rs_fetch vld=%b addr=%h inst=%h want vld=0 addr=40000200 inst=%h",
               bus.valid_out, bus.imem_addr, bus.inst_out, NOP_INST);
    end
    for (int i = 0; i < 2; i++) begin
      tick(); @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (bus.valid_out !== 1'b1 || bus.pc_out !== e || bus.inst_out !== memf(e)) begin
        bad++;
        $display("FAIL rs_seq vld=%b pc=%h inst=%h want vld=1 pc=%h inst=%h",
                 bus.valid_out, bus.pc_out, bus.inst_out, e, memf(e));
      end
    end
  endtask

  task automatic test_back_to_back();
    tick(); bus.redirect = 1'b1; bus.redirect_pc = 32'h4000_0300;
    tick(); bus.redirect_pc = 32'h4000_0400;
    @(negedge clk);
    total++;
    if (bus.valid_out !== 1'b0 || bus.imem_addr !== 32'h4000_0300) begin
      bad++;
      $display("FAIL b2b_second vld=%b addr=%h want vld=0 addr=40000300", bus.valid_out, bus.imem_addr);
    end
    tick(); bus.redirect = 1'b0;
    exp_q.push_back(32'h4000_0400);
    @(negedge clk);
    total++;
    if (bus.valid_out !== 1'b0 || bus.imem_addr !== 32'h4000_0400) begin
      bad++;
      $display("FAIL b2b_fetch vld=%b addr=%h want vld=0 addr=40000400", bus.valid_out, bus.imem_addr);
    end
    tick(); @(negedge clk);
    e = exp_q.pop_front();
    total++;
    if (bus.valid_out !== 1'b1 || bus.pc_out !== e || bus.inst_out !== memf(e)) begin
      bad++;
      $display("FAIL b2b_target vld=%b pc=%h inst=%h want vld=1 pc=%h inst=%h",
               bus.valid_out, bus.pc_out, bus.inst_out, e, memf(e));
    end
  endtask

  task automatic test_wrap();
    tick(); bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC;
    tick(); bus.redirect = 1'b0;
    exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0000_0000);
    @(negedge clk);
    total++;
    if (bus.imem_addr !== 32'hFFFF_FFFC) begin
      bad++;
      $display("FAIL wrap_fetch addr=%h want addr=fffffffc", bus.imem_addr);
    end
    tick(); @(negedge clk);
    total++;
    if (bus.imem_addr !== 32'h0000_0000) begin
      bad++;
      $display("FAIL wrap_next addr=%h want addr=00000000", bus.imem_addr);
    end
    for (int i = 0; i < 2; i++) begin
      if (i > 0) begin tick(); @(negedge clk); end
      e = exp_q.pop_front();
      total++;
      if (bus.valid_out !== 1'b1 || bus.pc_out !== e || bus.inst_out !== memf(e)) begin
        bad++;
        $display("FAIL wrap_seq vld=%b pc=%h inst=%h want vld=1 pc=%h inst=%h",
                 bus.valid_out, bus.pc_out, bus.inst_out, e, memf(e));
      end
    end
  endtask

  task automatic test_midreset();
    tick(); rst = 1'b1;
    @(negedge clk);
    total++;
    if (bus.valid_out !== 1'b0 || bus.imem_en !== 1'b0 || bus.inst_out !== NOP_INST) begin
      bad++;
      $display("FAIL midrst_state vld=%b en=%b inst=%h want vld=0 en=0 inst=%h",
               bus.valid_out, bus.imem_en, bus.inst_out, NOP_INST);
    end
    tick(); rst = 1'b0;
    exp_q.push_back(PC_RESET);
    @(negedge clk);
    total++;
    if (bus.valid_out !== 1'b0 || bus.imem_addr !== PC_RESET || bus.imem_en !== 1'b1) begin
      bad++;
      $display("FAIL midrst_fetch vld=%b addr=%h en=%b want vld=0 addr=%h en=1",
               bus.valid_out, bus.imem_addr, bus.imem_en, PC_RESET);
    end
    tick(); @(negedge clk);
    e = exp_q.pop_front();
    total++;
    if (bus.valid_out !== 1'b1 || bus.pc_out !== e || bus.inst_out !== memf(e)) begin
      bad++;
      $display("FAIL midrst_seq vld=%b pc=%h inst=%h want vld=1 pc=%h inst=%h",
               bus.valid_out, bus.pc_out, bus.inst_out, e, memf(e));
    end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_back_to_back();
    test_wrap();
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog sim time exceeded, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage of the RISC-V core. Sits directly upstream of the instruction decoder and control unit.
- Owns the PC register and issues word reads to the synchronous-read instruction memory (1-cycle latency). Presents one 32-bit instruction, with its PC, to decode each cycle.
- Handles decode stalls with a one-entry hold buffer.
- Handles branch/jump redirects from execute by squashing wrong-path instructions and injecting NOPs.

Parameters:
- PC_RESET, 32'h4000_0000, PC fetched first after reset.
- NOP_INST, 32'h0000_0013, instruction injected on bubbles (addi x0,x0,0).
- PC_WIDTH, 32, width of all PC/address signals.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  decode cannot accept; hold current output.
- redirect  input  1  taken branch/jump resolved in execute.
- redirect_pc  input  PC_WIDTH  target PC when redirect=1.
- imem_en  output  1  instruction memory read enable.
- imem_addr  output  PC_WIDTH  byte address of read; bits [1:0] always 0.
- imem_rdata  input  32  read data for the address issued in the previous cycle.
- inst_out  output  32  instruction to decoder.
- pc_out  output  PC_WIDTH  PC of inst_out.
- valid_out  output  1  inst_out is a real, non-squashed instruction.

Behaviour:
- State:
  - pc_q: PC of the fetch issued this cycle.
  - resp_vld_q, resp_pc_q: a fetch was issued last cycle; imem_rdata is valid now.
  - hold_vld_q, hold_inst_q: the hold buffer.
- Reset (rst=1 at an edge):
  - pc_q <= PC_RESET; resp_vld_q <= 0; hold_vld_q <= 0; resp_pc_q <= PC_RESET.
  - While rst=1: imem_en=0, valid_out=0, inst_out=NOP_INST, pc_out=resp_pc_q.
  - Reset asserted mid-operation discards all in-flight and held instructions.
- Memory request (combinational):
  - imem_addr = pc_q.
  - imem_en = !rst && (redirect || !stall).
- Output select (combinational):
  - If redirect=1: inst_out=NOP_INST and valid_out=0.
  - Else if hold_vld_q=1: inst_out=hold_inst_q, valid_out=1.
  - Else if resp_vld_q=1: inst_out=imem_rdata, valid_out=1.
  - Otherwise: inst_out=NOP_INST, valid_out=0.
  - pc_out = resp_pc_q in all cases.
- Normal advance (no rst, no redirect, stall=0):
  - pc_q <= pc_q+4, modulo 2^PC_WIDTH (wraps 0xFFFF_FFFC -> 0x0).
  - resp_vld_q <= 1; resp_pc_q <= pc_q; hold_vld_q <= 0.
- Stall (stall=1, redirect=0):
  - pc_q, resp_pc_q and resp_vld_q are unchanged.
  - If hold_vld_q=0 and resp_vld_q=1: hold_inst_q <= imem_rdata and hold_vld_q <= 1.
  - The outputs are identical every stalled cycle, regardless of what imem_rdata does while imem_en=0.
  - On the first cycle with stall=0, the held instruction is still shown. It is consumed at that edge and hold_vld_q <= 0.
- Redirect:
  - Redirect has priority over stall.
  - At the edge: pc_q <= {redirect_pc[PC_WIDTH-1:2],2'b00}; resp_vld_q <= 0; hold_vld_q <= 0.
  - The instruction in decode and the fetch in flight are both squashed.
  - Timeline, redirect in cycle t:
    - t: output squashed.
    - t+1: fetch of target issued, output NOP with valid=0.
    - t+2: target instruction shown, valid=1.
  - Branch penalty is 2 cycles.
  - Back-to-back redirects: the last one wins; each restarts the timeline.
- Steady state, no stalls: one valid instruction per cycle, PCs increment by 4. First valid instruction appears 2 cycles after rst falls.

Test Plan:
- Reset release: rst high 3 cycles then low, imem returns mem[pc] -> imem_addr=0x4000_0000 on cycle 1 after release; valid_out=1, pc_out=0x4000_0000 on cycle 2; then 0x4000_0004, 0x4000_0008 on consecutive cycles.
- Stall: stall=1 for 3 cycles while pc_out=0x4000_0008, imem_rdata driven to 0xDEADBEEF while imem_en=0 -> inst_out stays mem[0x4000_0008], valid_out=1, imem_en=0; after release, next output is 0x4000_000C with no duplicate or skip.
- Redirect: redirect=1 with redirect_pc=0x4000_0100 while pc_out=0x4000_0010 -> valid_out=0 in that cycle and the next; imem_addr=0x4000_0100 next cycle; pc_out=0x4000_0100 valid 2 cycles after redirect.
- Redirect+stall same cycle: stall=1, redirect=1, redirect_pc=0x4000_0203 -> redirect taken; imem_addr=0x4000_0200 next cycle; hold buffer cleared, no stale instruction emitted.
- Wrap and mid-run reset:
  - Redirect to 0xFFFF_FFFC -> the next sequential fetch address is 0x0000_0000.
  - Then rst=1 for 1 cycle -> valid_out=0; fetch restarts at 0x4000_0000.
